hier_node_sequencer: RTL
========================

Name: hier_node_sequencer

Overview:
- Parametrised tree-node controller that fans a start request out to NUM_CHILDREN child instances and fans their completions back in to a single done.
- Replaces fixed, port-less 5-child tree nodes. Child count is now a parameter, launch order is selectable (serial or parallel), and each run has timeout supervision.
- Nodes chain hierarchically: a parent's child_start_o / child_done_i connect to child nodes' start_i / done_o.

Parameters:
- NUM_CHILDREN, 5, number of child channels (1..32).
- SERIAL_MODE, 0, 0 = launch all children together; 1 = launch children one at a time in index order 0..N-1.
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before abort. 0 disables the timeout.
- CNT_W, 16, width of the timeout and perf counters. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  run request. Sampled only in IDLE.
- busy_o  output  1  high from LAUNCH through DONE/ERR.
- done_o  output  1  one-cycle completion pulse.
- err_o  output  1  valid with done_o: 1 = run aborted by timeout.
- child_start_o  output  NUM_CHILDREN  one-cycle start pulse per child.
- child_done_i  input  NUM_CHILDREN  child completion pulses or levels; treated as edge-insensitive sticky events.
- done_mask_o  output  NUM_CHILDREN  children completed in the current or last run.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - busy_o, done_o, err_o, child_start_o and done_mask_o all 0.
  - Counters cleared.
  - Reset mid-run aborts immediately; no done_o is issued.
- State machine (encoding in package): IDLE, LAUNCH, WAIT, DONE, ERR.
- IDLE:
  - start_i=1 -> LAUNCH next cycle.
  - Clear done_mask_o and the timeout counter; child index idx=0.
- LAUNCH (exactly one cycle):
  - Parallel mode: child_start_o = all ones.
  - Serial mode: child_start_o = one-hot(idx).
  - -> WAIT.
- WAIT:
  - Each cycle, done_mask_o |= child_done_i, restricted to launched children. Done from an unlaunched child is ignored.
  - Parallel mode: when the mask is all ones (including the update this cycle) -> DONE.
  - Serial mode: when bit idx becomes set:
    - if idx = N-1 -> DONE;
    - else idx++ and -> LAUNCH.
  - The timeout counter increments every WAIT cycle and resets on each LAUNCH.
  - When counter = TIMEOUT_CYCLES-1 with completion still pending -> ERR.
  - If completion and timeout occur in the same cycle, completion wins.
- DONE: done_o=1, err_o=0 for one cycle -> IDLE.
- ERR: done_o=1, err_o=1 for one cycle -> IDLE. done_mask_o keeps the partial mask until the next start.
- Latency, parallel mode with all children finishing in the first WAIT cycle: start_i at cycle 0 -> child_start_o at 1 -> done_o at 3.
- start_i while busy is ignored. No queuing.
- A child_done_i bit held high across a whole run counts once only; it does not retrigger.
- NUM_CHILDREN=1: serial and parallel modes behave identically.

Optional Feature:
- Macro: HIER_NODE_SEQUENCER_PERF_EN.
- When defined:
  - Adds output perf_cycles_o [CNT_W], the cycle count from LAUNCH entry to done_o.
  - Counter saturates at all ones and is cleared on start.
  - Holds its value until the next start.
  - Adds output perf_timeouts_o [8], a saturating count of ERR exits, cleared only by rst.
- When undefined: neither port exists, and neither does the logic.

Decomposition:
- Package hier_node_pkg:
  - node_state_e enum (IDLE, LAUNCH, WAIT, DONE, ERR);
  - MAX_CHILDREN=32 constant;
  - onehot function for serial launch.
- One sub-module, hier_node_timeout: CNT_W counter with clear, enable, and an expired flag against TIMEOUT_CYCLES; used by the controller. Bypassed entirely when TIMEOUT_CYCLES=0.

Test Plan:
- Parallel, N=5:
  - Stimulus: start_i pulse; children done at staggered cycles 2, 4, 4, 7, 9 after launch.
  - Response: child_start_o=5'b11111 for one cycle; done_o one cycle after the last done; err_o=0; done_mask_o=5'b11111.
- Serial, N=4, each child done 3 cycles after its start:
  - Response: child_start_o pulses 0001, 0010, 0100, 1000, each 4 cycles apart; single done_o afterwards.
- Timeout, TIMEOUT_CYCLES=8, child 2 never finishes:
  - Response: ERR after 8 WAIT cycles; done_o=1 with err_o=1; done_mask_o=5'b11011.
- Simultaneous events: last child done arrives in the same cycle the timeout expires.
  - Response: err_o=0.
- Reset mid-WAIT, then a new start:
  - Response: no done_o after the reset; all outputs 0; the new run completes normally.
- Spurious inputs: start_i while busy, and child_done_i pulses before launch.
  - Response: both ignored; mask unaffected. With PERF_EN, perf_cycles_o equals the measured latency.

Source files
------------

// File: rtl/hier_node_pkg.sv
// Shared state encoding and helpers for the hierarchical node sequencer.
package hier_node_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE,
        ERR
    } node_state_e;

    localparam int MAX_CHILDREN = 32;
    localparam int IDX_W        = $clog2(MAX_CHILDREN);

    function automatic logic [MAX_CHILDREN-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_CHILDREN-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hier_node_timeout.sv
// WAIT-phase watchdog: counts enabled cycles and flags the last permitted one.
module hier_node_timeout #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_W-1:0] cnt;

    // Holds at the terminal value so it can never wrap back below it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/hier_node_sequencer.sv
// Tree-node controller: fans start out to NUM_CHILDREN children and their completions back in.
// Optional perf counters are enabled with `define HIER_NODE_SEQUENCER_PERF_EN.
module hier_node_sequencer #(
    parameter int NUM_CHILDREN   = 5,
    parameter int SERIAL_MODE    = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [NUM_CHILDREN-1:0] child_start_o,
    input  logic [NUM_CHILDREN-1:0] child_done_i,
    output logic [NUM_CHILDREN-1:0] done_mask_o
`ifdef HIER_NODE_SEQUENCER_PERF_EN
    ,
    output logic [CNT_W-1:0]        perf_cycles_o,
    output logic [7:0]              perf_timeouts_o
`endif
);

    import hier_node_pkg::*;

    localparam bit                      SER     = (SERIAL_MODE != 0);
    localparam logic [MAX_CHILDREN-1:0] LSB_ONE = MAX_CHILDREN'(1);

    node_state_e             state;
    logic [IDX_W-1:0]        idx;
    logic [NUM_CHILDREN-1:0] idx_bit, launched, mask_nxt, start_pat, next_pat;
    logic                    go_done, go_next, go_err, tmo_expired;

    assign start_pat = SER ? NUM_CHILDREN'(LSB_ONE) : '1;
    assign next_pat  = SER ? NUM_CHILDREN'(onehot(idx + IDX_W'(1))) : '1;

    // In serial mode only children 0..idx have been started, so later done bits are noise.
    always_comb begin
        idx_bit  = NUM_CHILDREN'(onehot(idx));
        launched = SER ? NUM_CHILDREN'((onehot(idx) << 1) - LSB_ONE) : '1;
        mask_nxt = done_mask_o | (child_done_i & launched);
        go_done  = 1'b0;
        go_next  = 1'b0;
        go_err   = 1'b0;
        if (state == WAIT) begin
            if (SER) begin
                if ((mask_nxt & idx_bit) != '0) begin
                    go_done = (idx == IDX_W'(NUM_CHILDREN - 1));
                    go_next = (idx != IDX_W'(NUM_CHILDREN - 1));
                end
            end else begin
                go_done = &mask_nxt;
            end
            go_err = tmo_expired && !go_done && !go_next;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            hier_node_timeout #(
                .CNT_W          (CNT_W),
                .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
            ) u_tmo (
                .clk     (clk),
                .rst     (rst),
                .clr     (state != WAIT),
                .en      (state == WAIT),
                .expired (tmo_expired)
            );
        end else begin : g_no_tmo
            assign tmo_expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            child_start_o <= '0;
            done_mask_o   <= '0;
        end else begin
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            child_start_o <= '0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state         <= LAUNCH;
                        busy_o        <= 1'b1;
                        idx           <= '0;
                        done_mask_o   <= '0;
                        child_start_o <= start_pat;
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    done_mask_o <= mask_nxt;
                    if (go_done) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else if (go_next) begin
                        state         <= LAUNCH;
                        idx           <= idx + IDX_W'(1);
                        child_start_o <= next_pat;
                    end else if (go_err) begin
                        state  <= ERR;
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef HIER_NODE_SEQUENCER_PERF_EN
    // Run latency spans every LAUNCH/WAIT cycle, so it reads final while done_o is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles_o   <= '0;
            perf_timeouts_o <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                perf_cycles_o <= '0;
            end else if ((state == LAUNCH || state == WAIT) && perf_cycles_o != '1) begin
                perf_cycles_o <= perf_cycles_o + CNT_W'(1);
            end
            if (go_err && perf_timeouts_o != 8'hFF) begin
                perf_timeouts_o <= perf_timeouts_o + 8'd1;
            end
        end
    end
`endif

endmodule
